// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: controller states,
// digit width and the wrap limits used by the digit counters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] LIMIT_NINE = 4'd9;
    localparam logic [DIGIT_W-1:0] LIMIT_FIVE = 4'd5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..LIMIT and wraps to 0, raising a combinational
// carry in the cycle its increment causes the wrap.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = LIMIT_NINE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic [DIGIT_W-1:0] r_digit;

    // Using >= rather than == means a corrupted value still recovers to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= (r_digit >= LIMIT) ? '0 : r_digit + 1'b1;
        end
    end

    assign carry = inc && (r_digit >= LIMIT);
    assign digit = r_digit;

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch with IDLE/RUN/PAUSE control and a tick prescaler.
// Defining STOPWATCH_LAP_EN adds a lap input that freezes the displayed digits.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_stop,
    input  logic               clear,
`ifdef STOPWATCH_LAP_EN
    input  logic               lap,
`endif
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               running,
    output logic               rollover
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [15:0]        r_presc;
    logic               r_rollover;
    logic               w_accept;
    logic               w_secInc;
    logic               w_c0, w_c1, w_c2, w_c3;
    logic [DIGIT_W-1:0] w_so, w_st, w_mo, w_mt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (clear) begin
            w_nextState = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE:    w_nextState = RUN;
                RUN:     w_nextState = PAUSE;
                PAUSE:   w_nextState = RUN;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Only the current state qualifies a tick, so one arriving on the
    // RUN->PAUSE edge counts while one on the edge into RUN is dropped.
    assign w_accept = tick && !clear && (r_state == RUN);
    assign w_secInc = w_accept && (r_presc == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (clear) begin
            r_presc <= '0;
        end else if (w_accept) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 16'd1;
        end
    end

    bcd_digit_counter #(.LIMIT(LIMIT_NINE)) u_secOnes (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_secInc), .digit(w_so), .carry(w_c0)
    );
    bcd_digit_counter #(.LIMIT(LIMIT_FIVE)) u_secTens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c0), .digit(w_st), .carry(w_c1)
    );
    bcd_digit_counter #(.LIMIT(LIMIT_NINE)) u_minOnes (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c1), .digit(w_mo), .carry(w_c2)
    );
    bcd_digit_counter #(.LIMIT(LIMIT_FIVE)) u_minTens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c2), .digit(w_mt), .carry(w_c3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rollover <= 1'b0;
        else     r_rollover <= w_c3;
    end

    assign running  = (r_state == RUN);
    assign rollover = r_rollover;

`ifdef STOPWATCH_LAP_EN
    logic                 r_hold;
    logic [4*DIGIT_W-1:0] r_snap;

    // Snapshot takes the count shown before the lap edge; counting carries on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 1'b0;
            r_snap <= '0;
        end else if (clear) begin
            r_hold <= 1'b0;
        end else if (r_state == RUN) begin
            if (start_stop) begin
                r_hold <= 1'b0;
            end else if (lap) begin
                r_hold <= !r_hold;
                if (!r_hold) r_snap <= {w_mt, w_mo, w_st, w_so};
            end
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} =
        r_hold ? r_snap : {w_mt, w_mo, w_st, w_so};
`else
    assign {min_tens, min_ones, sec_tens, sec_ones} = {w_mt, w_mo, w_st, w_so};
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: two instances (TICK_DIV 1 and 4) share
// stimulus and are checked against a seconds-count reference model.
module tb_stopwatch_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start_stop;
    logic       clear;
`ifdef STOPWATCH_LAP_EN
    logic       lap;
`endif
    logic [3:0] so1, st1, mo1, mt1, so4, st4, mo4, mt4;
    logic       run1, roll1, run4, roll4;

    typedef struct {
        logic [15:0] bcd;
        logic        running;
        logic        rollover;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int totalCount = 0;
    int badCount   = 0;

    // Reference model per instance: elapsed whole seconds plus a tick counter.
    int divs [2] = '{1, 4};
    int mMode[2];
    int mSecs[2];
    int mPre [2];
    int mSnap[2];
    bit mHold[2];
    bit mRoll[2];

    stopwatch_bcd #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .rollover(roll1)
    );

    stopwatch_bcd #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_ones(so4), .sec_tens(st4), .min_ones(mo4), .min_tens(mt4),
        .running(run4), .rollover(roll4)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic exp_t modelView(input int k);
        exp_t e;
        e.bcd      = mHold[k] ? toBcd(mSnap[k]) : toBcd(mSecs[k]);
        e.running  = (mMode[k] == 1);
        e.rollover = mRoll[k];
        return e;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mMode[k] = 0; mSecs[k] = 0; mPre[k] = 0;
            mSnap[k] = 0; mHold[k] = 1'b0; mRoll[k] = 1'b0;
        end
    endtask

    // Mode encoding here: 0 stopped-at-zero, 1 counting, 2 frozen.
    task automatic modelStep(input int k, input bit tk, input bit ss, input bit cl, input bit lp);
        bit counting;
        if (cl) begin
            mMode[k] = 0; mSecs[k] = 0; mPre[k] = 0; mRoll[k] = 1'b0; mHold[k] = 1'b0;
        end else begin
            counting = (mMode[k] == 1);
            mRoll[k] = 1'b0;
            if (counting && ss) begin
                mHold[k] = 1'b0;
            end else if (counting && lp) begin
                if (!mHold[k]) mSnap[k] = mSecs[k];
                mHold[k] = !mHold[k];
            end
            if (counting && tk) begin
                mPre[k]++;
                if (mPre[k] == divs[k]) begin
                    mPre[k] = 0;
                    mSecs[k]++;
                    if (mSecs[k] == 3600) begin
                        mSecs[k] = 0;
                        mRoll[k] = 1'b1;
                    end
                end
            end
            if (ss) mMode[k] = (mMode[k] == 1) ? 2 : 1;
        end
    endtask

    task automatic checkOutput(input string name, input int k, input exp_t e);
        logic [15:0] aBcd;
        logic        aRun, aRoll;
        if (k == 0) begin
            aBcd = {mt1, mo1, st1, so1}; aRun = run1; aRoll = roll1;
        end else begin
            aBcd = {mt4, mo4, st4, so4}; aRun = run4; aRoll = roll4;
        end
        totalCount++;
        if (aBcd !== e.bcd || aRun !== e.running || aRoll !== e.rollover) begin
            badCount++;
            $display("[TB] FAIL %s div=%0d t=%0t: got mm:ss=%h run=%b roll=%b, want mm:ss=%h run=%b roll=%b",
                     name, divs[k], $time, aBcd, aRun, aRoll, e.bcd, e.running, e.rollover);
        end
    endtask

    // Drive one cycle of inputs and queue what each instance should show after the edge.
    task automatic applyStimulus(input bit tk, input bit ss, input bit cl, input bit lp);
        @(posedge clk);
        #2;
        tick = tk; start_stop = ss; clear = cl;
`ifdef STOPWATCH_LAP_EN
        lap = lp;
`endif
        for (int k = 0; k < 2; k++) modelStep(k, tk, ss, cl, lp);
        q1.push_back(modelView(0));
        q4.push_back(modelView(1));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset lands between edges; outputs must already be zero 1 ns later.
    task automatic asyncReset();
        @(posedge clk);
        #4;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset", 0, modelView(0));
        checkOutput("async_reset", 1, modelView(1));
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: one scoreboard entry per edge, sampled 1 ns after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) checkOutput("scoreboard", 0, q1.pop_front());
            if (q4.size() > 0) checkOutput("scoreboard", 1, q4.pop_front());
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        modelReset();
        #3;
        checkOutput("power_on_reset", 0, modelView(0));
        checkOutput("power_on_reset", 1, modelView(1));
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Ticks before any start are ignored, then ten counted seconds.
        ticks(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);

        // Pause in the middle of a prescaler period and resume.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);

        // Tick on the pause edge counts, tick on the resume edge does not.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        ticks(2);

        // Clear beats start_stop and tick in the same cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(42);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset at 01:05, then ticks wait for a fresh start.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(65);
        asyncReset();
        ticks(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);

        // Full hour on the undivided instance: 59:59 then wrap with rollover.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3600);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(2);
`endif

        // Randomised soak with rare commands.
        for (int i = 0; i < 6000; i++) begin
            applyStimulus($urandom_range(0, 7) != 0,
                          $urandom_range(0, 63) == 0,
                          $urandom_range(0, 1499) == 0,
`ifdef STOPWATCH_LAP_EN
                          $urandom_range(0, 31) == 0
`else
                          1'b0
`endif
                          );
        end

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        totalCount++;
        if (q1.size() != 0 || q4.size() != 0) begin
            badCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d entries left, want 0/0", q1.size(), q4.size());
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
